// File: rtl/spi_cmd_decoder_pkg.sv
// ---------------------------------------------------------------------------
// ols_cmd_pkg
//   Shared definitions for the SPI command decoder: analyzer opcodes, the
//   decoder FSM state type, the strobe bundle and the opcode-to-strobe decode.
//   No ports (package).
// ---------------------------------------------------------------------------
package ols_cmd_pkg;

    // Short commands (single byte, opcode < 0x80)
    localparam logic [7:0] OP_RESET      = 8'h00;
    localparam logic [7:0] OP_ARM        = 8'h01;
    localparam logic [7:0] OP_ID         = 8'h02;
    localparam logic [7:0] OP_META       = 8'h04;
    localparam logic [7:0] OP_RLE_CANCEL = 8'h05;
    // Host read filler: dropped when it arrives in place of an opcode
    localparam logic [7:0] OP_NOP        = 8'h7F;

    // Long commands (opcode >= 0x80, four argument bytes LSB first)
    localparam logic [7:0] OP_DIVIDER    = 8'h80;
    localparam logic [7:0] OP_COUNT      = 8'h81;
    localparam logic [7:0] OP_FLAGS      = 8'h82;
    // 0xC0..0xCF: opcode[3:2] = trigger stage, opcode[1:0] = trigger register
    localparam logic [7:0] OP_TRIG_BASE  = 8'hC0;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        ARG0 = 3'd1,
        ARG1 = 3'd2,
        ARG2 = 3'd3,
        ARG3 = 3'd4
    } cmd_state_t;

    typedef struct packed {
        logic soft_reset;
        logic arm;
        logic query_id;
        logic query_meta;
        logic rle_cancel;
        logic wr_divider;
        logic wr_count;
        logic wr_flags;
        logic wr_trigger;
    } cmd_strobes_t;

    // One opcode selects at most one strobe, so the strobes are mutually
    // exclusive by construction. Unknown opcodes select none.
    function automatic cmd_strobes_t decode_opcode(input logic [7:0] op);
        cmd_strobes_t s;
        s = '0;
        case (op)
            OP_RESET:      s.soft_reset = 1'b1;
            OP_ARM:        s.arm        = 1'b1;
            OP_ID:         s.query_id   = 1'b1;
            OP_META:       s.query_meta = 1'b1;
            OP_RLE_CANCEL: s.rle_cancel = 1'b1;
            OP_DIVIDER:    s.wr_divider = 1'b1;
            OP_COUNT:      s.wr_count   = 1'b1;
            OP_FLAGS:      s.wr_flags   = 1'b1;
            default:       s.wr_trigger = (op[7:4] == OP_TRIG_BASE[7:4]);
        endcase
        return s;
    endfunction

endpackage

// File: rtl/spi_cmd_decoder_if.sv
// ---------------------------------------------------------------------------
// spi_cmd_decoder_if
//   Byte stream from the SPI slave byte engine and the decoded command /
//   strobe bundle going to the analyzer core.
//   Byte handshake: rx_valid is a one-cycle pulse with rx_data valid in the
//   same cycle; there is no ready, the decoder accepts a byte on every clock.
//   Command side: cmd_valid and at most one strobe pulse for one cycle;
//   cmd_opcode / cmd_data / trig_* hold until the next update.
//   Modports:
//     master - byte engine / core side (drives rx_*, observes commands)
//     slave  - decoder side (observes rx_*, drives commands and busy)
// ---------------------------------------------------------------------------
interface spi_cmd_decoder_if;

    logic        rx_valid;
    logic [7:0]  rx_data;

    logic        cmd_valid;
    logic [7:0]  cmd_opcode;
    logic [31:0] cmd_data;
    logic        soft_reset;
    logic        arm;
    logic        query_id;
    logic        query_meta;
    logic        rle_cancel;
    logic        wr_divider;
    logic        wr_count;
    logic        wr_flags;
    logic        wr_trigger;
    logic [1:0]  trig_stage;
    logic [1:0]  trig_reg;
    logic        busy;

    modport master (
        output rx_valid, rx_data,
        input  cmd_valid, cmd_opcode, cmd_data,
        input  soft_reset, arm, query_id, query_meta, rle_cancel,
        input  wr_divider, wr_count, wr_flags, wr_trigger,
        input  trig_stage, trig_reg, busy
    );

    modport slave (
        input  rx_valid, rx_data,
        output cmd_valid, cmd_opcode, cmd_data,
        output soft_reset, arm, query_id, query_meta, rle_cancel,
        output wr_divider, wr_count, wr_flags, wr_trigger,
        output trig_stage, trig_reg, busy
    );

endinterface

// File: rtl/spi_cmd_decoder.sv
// ---------------------------------------------------------------------------
// spi_cmd_decoder
//   Assembles SPI host bytes into analyzer commands. Short commands are one
//   byte (< 0x80); long commands are an opcode (>= 0x80) plus four argument
//   bytes, LSB first. A completed command produces cmd_valid and its strobe
//   exactly one clock after the final byte. A partial long command is
//   discarded after TIMEOUT_CYCLES idle clocks.
//   Ports:
//     clock      - system clock
//     reset_n    - asynchronous active-low reset
//     bus        - spi_cmd_decoder_if.slave (rx byte in, command/strobes out)
//     dbg_state  - current FSM state, for observation only
// ---------------------------------------------------------------------------
module spi_cmd_decoder
    import ols_cmd_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 65536
) (
    input  logic               clock,
    input  logic               reset_n,
    spi_cmd_decoder_if.slave   bus,
    output cmd_state_t         dbg_state
);

    localparam int unsigned CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT_CYCLES - 1);

    cmd_state_t    state, state_next;
    logic [7:0]    op_q, op_next;
    logic [23:0]   arg_q, arg_next;   // bytes 0..2; byte 3 goes straight to the output
    logic [CW-1:0] tmo_q;
    logic          tmo_expire;

    logic          fire;
    logic [7:0]    fire_op;
    logic [31:0]   fire_data;
    cmd_strobes_t  fire_strobes;

    logic          cmd_valid_q;
    logic [7:0]    cmd_opcode_q;
    logic [31:0]   cmd_data_q;
    cmd_strobes_t  strobes_q;
    logic [1:0]    trig_stage_q;
    logic [1:0]    trig_reg_q;

    // A received byte always beats an expiring timeout in the same cycle.
    assign tmo_expire = (state != IDLE) && !bus.rx_valid && (tmo_q == TMO_LAST);

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            op_q  <= '0;
            arg_q <= '0;
        end else begin
            state <= state_next;
            op_q  <= op_next;
            arg_q <= arg_next;
        end
    end

    always_comb begin
        state_next = state;
        op_next    = op_q;
        arg_next   = arg_q;
        fire       = 1'b0;
        fire_op    = op_q;
        fire_data  = '0;

        case (state)
            IDLE: begin
                if (bus.rx_valid && bus.rx_data != OP_NOP) begin
                    if (!bus.rx_data[7]) begin
                        fire    = 1'b1;
                        fire_op = bus.rx_data;
                    end else begin
                        op_next    = bus.rx_data;
                        arg_next   = '0;
                        state_next = ARG0;
                    end
                end
            end
            ARG0: begin
                if (bus.rx_valid) begin
                    arg_next[7:0] = bus.rx_data;
                    state_next    = ARG1;
                end
            end
            ARG1: begin
                if (bus.rx_valid) begin
                    arg_next[15:8] = bus.rx_data;
                    state_next     = ARG2;
                end
            end
            ARG2: begin
                if (bus.rx_valid) begin
                    arg_next[23:16] = bus.rx_data;
                    state_next      = ARG3;
                end
            end
            ARG3: begin
                if (bus.rx_valid) begin
                    fire       = 1'b1;
                    fire_op    = op_q;
                    fire_data  = {bus.rx_data, arg_q};
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase

        // Partial command abandoned by the host: drop it silently.
        if (tmo_expire) begin
            state_next = IDLE;
        end
    end

    // ------------------------------------------------------- idle timeout
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            tmo_q <= '0;
        end else if (bus.rx_valid || state == IDLE || tmo_expire) begin
            tmo_q <= '0;
        end else begin
            tmo_q <= tmo_q + CW'(1);
        end
    end

    // ------------------------------------------------ registered decode
    assign fire_strobes = decode_opcode(fire_op);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cmd_valid_q  <= 1'b0;
            cmd_opcode_q <= '0;
            cmd_data_q   <= '0;
            strobes_q    <= '0;
            trig_stage_q <= '0;
            trig_reg_q   <= '0;
        end else begin
            cmd_valid_q <= fire;
            strobes_q   <= fire ? fire_strobes : '0;
            if (fire) begin
                cmd_opcode_q <= fire_op;
                cmd_data_q   <= fire_data;
            end
            if (fire && fire_strobes.wr_trigger) begin
                trig_stage_q <= fire_op[3:2];
                trig_reg_q   <= fire_op[1:0];
            end
        end
    end

    // ------------------------------------------------------------ outputs
    assign bus.cmd_valid  = cmd_valid_q;
    assign bus.cmd_opcode = cmd_opcode_q;
    assign bus.cmd_data   = cmd_data_q;
    assign bus.soft_reset = strobes_q.soft_reset;
    assign bus.arm        = strobes_q.arm;
    assign bus.query_id   = strobes_q.query_id;
    assign bus.query_meta = strobes_q.query_meta;
    assign bus.rle_cancel = strobes_q.rle_cancel;
    assign bus.wr_divider = strobes_q.wr_divider;
    assign bus.wr_count   = strobes_q.wr_count;
    assign bus.wr_flags   = strobes_q.wr_flags;
    assign bus.wr_trigger = strobes_q.wr_trigger;
    assign bus.trig_stage = trig_stage_q;
    assign bus.trig_reg   = trig_reg_q;
    assign bus.busy       = (state != IDLE);

    assign dbg_state = state;

endmodule

// File: tb/tb_spi_cmd_decoder.sv
// ---------------------------------------------------------------------------
// tb_spi_cmd_decoder
//   Drives byte streams into spi_cmd_decoder and checks every emitted command
//   against a byte-level reference model (pending-byte queue + idle counter).
// ---------------------------------------------------------------------------
module tb_spi_cmd_decoder;
    import ols_cmd_pkg::*;

    localparam int T = 64;      // shortened timeout keeps the run small
    localparam int W = 72;      // {due cycle[31:0], opcode[7:0], data[31:0]}

    // ------------------------------------------------ clock / reset
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    cmd_state_t dbg_state;
    int unsigned cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    spi_cmd_decoder_if bus ();

    spi_cmd_decoder #(.TIMEOUT_CYCLES(T)) dut (
        .clock     (clk),
        .reset_n   (rst_n),
        .bus       (bus),
        .dbg_state (dbg_state)
    );

    // ------------------------------------------------ scoreboard state
    int errors = 0;
    int checks = 0;
    logic [W-1:0] exp_q[$];
    logic [7:0]   pend[$];      // bytes of a partially received long command
    int           idle_cnt = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Strobe vector {soft,arm,id,meta,rle,div,count,flags,trig} from the opcode table.
    function automatic logic [8:0] exp_strobes(input logic [7:0] op);
        if (op == 8'h00) return 9'b1_0000_0000;
        if (op == 8'h01) return 9'b0_1000_0000;
        if (op == 8'h02) return 9'b0_0100_0000;
        if (op == 8'h04) return 9'b0_0010_0000;
        if (op == 8'h05) return 9'b0_0001_0000;
        if (op == 8'h80) return 9'b0_0000_1000;
        if (op == 8'h81) return 9'b0_0000_0100;
        if (op == 8'h82) return 9'b0_0000_0010;
        if (op >= 8'hC0 && op <= 8'hCF) return 9'b0_0000_0001;
        return 9'b0;
    endfunction

    // ------------------------------------------------ reference model
    task automatic model_byte(input logic [7:0] b);
        logic [31:0] due;
        due = cyc + 1;
        idle_cnt = 0;
        if (pend.size() == 0) begin
            if (b == 8'h7F) begin
                // host filler, dropped
            end else if (b < 8'h80) begin
                exp_q.push_back({due, b, 32'h0});
            end else begin
                pend.push_back(b);
            end
        end else begin
            pend.push_back(b);
            if (pend.size() == 5) begin
                exp_q.push_back({due, pend[0], pend[4], pend[3], pend[2], pend[1]});
                pend.delete();
            end
        end
    endtask

    // ------------------------------------------------ driver tasks
    task automatic send(input logic [7:0] b);
        @(negedge clk);
        check("busy", 64'(bus.busy), 64'(pend.size() != 0));
        bus.rx_valid = 1'b1;
        bus.rx_data  = b;
        model_byte(b);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            check("busy", 64'(bus.busy), 64'(pend.size() != 0));
            bus.rx_valid = 1'b0;
            bus.rx_data  = 8'($urandom);
            if (pend.size() != 0) begin
                idle_cnt++;
                if (idle_cnt == T) begin
                    pend.delete();
                    idle_cnt = 0;
                end
            end
        end
    endtask

    task automatic send_seq(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                            input logic [7:0] b3, input logic [7:0] b4);
        send(b0); send(b1); send(b2); send(b3); send(b4);
    endtask

    task automatic check_reset_state();
        check("rst_cmd_valid", 64'(bus.cmd_valid), 64'h0);
        check("rst_opcode", 64'(bus.cmd_opcode), 64'h0);
        check("rst_data", 64'(bus.cmd_data), 64'h0);
        check("rst_strobes", 64'({bus.soft_reset, bus.arm, bus.query_id, bus.query_meta,
              bus.rle_cancel, bus.wr_divider, bus.wr_count, bus.wr_flags, bus.wr_trigger}), 64'h0);
        check("rst_busy", 64'(bus.busy), 64'h0);
        check("rst_state", 64'(dbg_state), 64'(IDLE));
    endtask

    task automatic do_reset();
        idle(1);
        @(negedge clk);
        #1 rst_n = 1'b0;
        pend.delete();
        idle_cnt = 0;
        #1 check_reset_state();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // ------------------------------------------------ monitor
    always @(negedge clk) begin
        logic [8:0]   s;
        logic [W-1:0] e;
        if (rst_n) begin
            s = {bus.soft_reset, bus.arm, bus.query_id, bus.query_meta, bus.rle_cancel,
                 bus.wr_divider, bus.wr_count, bus.wr_flags, bus.wr_trigger};
            if (bus.cmd_valid) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_cmd", 64'(bus.cmd_opcode), 64'hFFFF);
                end else begin
                    e = exp_q.pop_front();
                    check("cmd_cycle", 64'(cyc), 64'(e[71:40]));
                    check("cmd_opcode", 64'(bus.cmd_opcode), 64'(e[39:32]));
                    check("cmd_data", 64'(bus.cmd_data), 64'(e[31:0]));
                    check("strobes", 64'(s), 64'(exp_strobes(e[39:32])));
                    if (e[39:36] == 4'hC) begin
                        check("trig_stage", 64'(bus.trig_stage), 64'(e[35:34]));
                        check("trig_reg", 64'(bus.trig_reg), 64'(e[33:32]));
                    end
                end
            end else begin
                check("idle_strobes", 64'(s), 64'h0);
                if (exp_q.size() != 0 && exp_q[0][71:40] <= cyc) begin
                    e = exp_q.pop_front();
                    check("cmd_missing", 64'(e[39:32]), 64'hFFFF);
                end
            end
        end
    end

    // ------------------------------------------------ watchdog
    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not complete (checks=%0d)", checks);
        $fatal(1, "watchdog expired");
    end

    // ------------------------------------------------ stimulus
    initial begin
        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'h00;
        repeat (3) @(negedge clk);
        check_reset_state();
        rst_n = 1'b1;
        idle(2);

        // five resets then an ID query, back to back
        repeat (5) send(8'h00);
        send(8'h02);
        idle(2);

        // divider write
        send_seq(8'h80, 8'h02, 8'h00, 8'h00, 8'h00);
        idle(2);

        // trigger stage 0, config register
        send_seq(8'hC2, 8'h00, 8'h00, 8'h00, 8'h08);
        idle(2);

        // abandoned flags write, then arm
        send(8'h82); send(8'h00);
        idle(T);
        send(8'h01);
        idle(2);

        // byte arriving on the last idle clock before expiry is still accepted
        send(8'h82); send(8'h00);
        idle(T - 1);
        send(8'h11); send(8'h22); send(8'h33);
        idle(2);

        // leading fillers, then a count write whose data contains 0x7F
        repeat (3) send(8'h7F);
        send_seq(8'h81, 8'h7F, 8'h00, 8'h0F, 8'h00);
        idle(2);

        // resync from inside a long command
        send(8'hC1);
        repeat (5) send(8'h00);
        idle(2);

        // undefined short and long opcodes
        send(8'h10);
        send_seq(8'h83, 8'hAA, 8'hBB, 8'hCC, 8'hDD);
        send_seq(8'hD0, 8'h01, 8'h02, 8'h03, 8'h04);
        send_seq(8'hCF, 8'hFF, 8'hFF, 8'hFF, 8'hFF);
        idle(2);

        // asynchronous reset mid-command
        send(8'hC1); send(8'h11); send(8'h22);
        do_reset();
        send(8'h05);
        idle(3);

        // randomized traffic
        for (int i = 0; i < 600; i++) begin
            int r;
            r = $urandom_range(0, 11);
            case (r)
                0, 1: idle($urandom_range(1, 3));
                2: idle(T - 2 + $urandom_range(0, 3));
                3: send(8'h7F);
                4: send(8'($urandom_range(0, 7)));
                5: send(8'h00);
                6: begin
                    int k;
                    k = $urandom_range(0, 5);
                    case (k)
                        0: send(8'h80);
                        1: send(8'h81);
                        2: send(8'h82);
                        3: send(8'hC0 + 8'($urandom_range(0, 15)));
                        4: send(8'h83);
                        default: send(8'hD0);
                    endcase
                end
                7: if ($urandom_range(0, 9) == 0) do_reset(); else idle(1);
                default: send(8'($urandom));
            endcase
        end

        idle(T + 5);
        check("queue_drained", 64'(exp_q.size()), 64'h0);
        check("end_busy", 64'(bus.busy), 64'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
